// File: rtl/sc_backgctrl_scheduler.sv
// Sequencer for the 8-bit background-type shift register: clear/load/rotate/transition strobes.
// Optional macro SC_BACKGCTRL_PAUSE_EN: pause_In freezes the RUN prescaler and shift count.
module sc_backgctrl_scheduler #(
  parameter int DATAWIDTH      = 8,
  parameter int BASE_PERIOD    = 25000000,
  parameter int CNT_WIDTH      = 26,
  parameter int SHIFTS_PER_DIR = 8,
  parameter int TRANS_CYCLES   = 4
) (
  input  logic                 SC_BACKGCTRL_CLOCK_50,
  input  logic                 SC_BACKGCTRL_RESET_InLow,
  input  logic                 SC_BACKGCTRL_start_InLow,
  input  logic                 SC_BACKGCTRL_stop_InLow,
  input  logic                 SC_BACKGCTRL_pause_In,
  input  logic [1:0]           SC_BACKGCTRL_level_InBUS,
  input  logic [DATAWIDTH-1:0] SC_BACKGCTRL_pattern_InBUS,
  output logic                 SC_BACKGCTRL_clear_OutLow,
  output logic                 SC_BACKGCTRL_load_OutLow,
  output logic [1:0]           SC_BACKGCTRL_shiftselection_OutBUS,
  output logic                 SC_BACKGCTRL_transition_Out,
  output logic [DATAWIDTH-1:0] SC_BACKGCTRL_transitionDATA_OutBUS,
  output logic                 SC_BACKGCTRL_busy_Out,
  output logic [2:0]           SC_BACKGCTRL_state_OutBUS
);
  localparam int SW = (SHIFTS_PER_DIR > 1) ? $clog2(SHIFTS_PER_DIR) : 1;
  localparam int TW = (TRANS_CYCLES > 1) ? $clog2(TRANS_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE = 3'd0, CLEAR = 3'd1, LOAD = 3'd2, RUN = 3'd3, TRANS = 3'd4} state_t;

  state_t               stateQ, stateD;
  logic [CNT_WIDTH-1:0] preCntQ, preCntD, periodM1;
  logic [CNT_WIDTH:0]   periodRaw;
  logic [SW-1:0]        shiftCntQ, shiftCntD;
  logic [TW-1:0]        transCntQ, transCntD;
  logic                 dirQ, dirD;
  logic [1:0]           levelQ, levelD;
  logic                 clearQ, loadQ, transQ, busyQ;
  logic [1:0]           shiftQ, shiftD;
  logic [DATAWIDTH-1:0] transDataQ, transDataD;
  logic                 pauseActive;
  logic [1:0]           rstPipe;
  logic                 rstN;

  // Assert immediately, release on a clock edge.
  always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or negedge SC_BACKGCTRL_RESET_InLow)
    if (!SC_BACKGCTRL_RESET_InLow) rstPipe <= 2'b00;
    else                           rstPipe <= {rstPipe[0], 1'b1};
  assign rstN = rstPipe[1];

`ifdef SC_BACKGCTRL_PAUSE_EN
  assign pauseActive = SC_BACKGCTRL_pause_In;
`else
  logic unusedPause;
  assign unusedPause = SC_BACKGCTRL_pause_In;
  assign pauseActive = 1'b0;
`endif

  // Period shrinks by 2x per level, never below 2 cycles.
  assign periodRaw = (CNT_WIDTH+1)'(BASE_PERIOD) >> levelQ;
  assign periodM1  = (periodRaw < (CNT_WIDTH+1)'(2)) ? CNT_WIDTH'(1) : CNT_WIDTH'(periodRaw - 1'b1);

  always_comb begin
    stateD    = stateQ;
    preCntD   = preCntQ;
    shiftCntD = shiftCntQ;
    transCntD = transCntQ;
    dirD      = dirQ;
    levelD    = levelQ;
    shiftD    = 2'b00;
    case (stateQ)
      IDLE:  if (!SC_BACKGCTRL_start_InLow) stateD = CLEAR;
      CLEAR: stateD = LOAD;
      LOAD: begin
        stateD    = RUN;
        levelD    = SC_BACKGCTRL_level_InBUS;
        preCntD   = '0;
        shiftCntD = '0;
        dirD      = 1'b0;
      end
      RUN: begin
        if (SC_BACKGCTRL_level_InBUS != levelQ) begin
          // Level change wins over a tick due this cycle.
          stateD    = TRANS;
          levelD    = SC_BACKGCTRL_level_InBUS;
          preCntD   = '0;
          shiftCntD = '0;
          transCntD = '0;
          dirD      = 1'b0;
        end else if (!pauseActive) begin
          if (preCntQ == periodM1) begin
            preCntD = '0;
            shiftD  = dirQ ? 2'b10 : 2'b01;
            if (shiftCntQ == SW'(SHIFTS_PER_DIR-1)) begin
              shiftCntD = '0;
              dirD      = ~dirQ;
            end else begin
              shiftCntD = shiftCntQ + 1'b1;
            end
          end else begin
            preCntD = preCntQ + 1'b1;
          end
        end
      end
      TRANS: begin
        if (transCntQ == TW'(TRANS_CYCLES-1)) stateD = RUN;
        else                                  transCntD = transCntQ + 1'b1;
      end
      default: stateD = IDLE;
    endcase
    if (stateQ != IDLE && !SC_BACKGCTRL_stop_InLow) begin
      stateD    = IDLE;
      shiftD    = 2'b00;
      preCntD   = '0;
      shiftCntD = '0;
      transCntD = '0;
      dirD      = 1'b0;
      levelD    = 2'd0;
    end
    // Data is captured on TRANS entry and held for the whole strobe.
    transDataD = '0;
    if (stateD == TRANS)
      transDataD = (stateQ == TRANS) ? transDataQ : SC_BACKGCTRL_pattern_InBUS;
  end

  always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or negedge rstN) begin
    if (!rstN) begin
      stateQ     <= IDLE;
      preCntQ    <= '0;
      shiftCntQ  <= '0;
      transCntQ  <= '0;
      dirQ       <= 1'b0;
      levelQ     <= 2'd0;
      clearQ     <= 1'b1;
      loadQ      <= 1'b1;
      shiftQ     <= 2'b00;
      transQ     <= 1'b0;
      transDataQ <= '0;
      busyQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      preCntQ    <= preCntD;
      shiftCntQ  <= shiftCntD;
      transCntQ  <= transCntD;
      dirQ       <= dirD;
      levelQ     <= levelD;
      clearQ     <= (stateD != CLEAR);
      loadQ      <= (stateD != LOAD);
      shiftQ     <= shiftD;
      transQ     <= (stateD == TRANS);
      transDataQ <= transDataD;
      busyQ      <= (stateD != IDLE);
    end
  end

  assign SC_BACKGCTRL_clear_OutLow          = clearQ;
  assign SC_BACKGCTRL_load_OutLow           = loadQ;
  assign SC_BACKGCTRL_shiftselection_OutBUS = shiftQ;
  assign SC_BACKGCTRL_transition_Out        = transQ;
  assign SC_BACKGCTRL_transitionDATA_OutBUS = transDataQ;
  assign SC_BACKGCTRL_busy_Out              = busyQ;
  assign SC_BACKGCTRL_state_OutBUS          = stateQ;
endmodule
